// File: rtl/rs_enc_framer.sv
// rs_enc_framer: transmit-side framer ahead of the RS encoder.
// Buffers 64-bit payload words, gathers one ISOS sync bit per word pair and,
// once a whole frame is buffered, emits FRAME_WORDS data words followed by a
// tail word carrying the sync bits at [59:48] (parity is overlaid downstream).
//
// Handshake semantics (both sides): a word moves on a rising clk edge where
// valid & ready are both high. push_rdy depends only on internal state, never
// on push_vld. out_vld/out_data/out_last are registered; once out_vld is high
// the word holds stable until out_rdy is seen, and out_vld never drops
// without a transfer.
module rs_enc_framer #(
   parameter int FRAME_WORDS = 24,  // payload words per frame, must be even
   parameter int AW          = 5    // data FIFO address width, 2**AW >= FRAME_WORDS
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        push_vld,
   output logic        push_rdy,
   input  logic [63:0] push_data,
   input  logic        push_isos,
   input  logic        out_rdy,
   output logic        out_vld,
   output logic [63:0] out_data,
   output logic        out_last,
   output logic [15:0] frame_cnt,
   output logic [1:0]  dbg_state
);

   localparam int SW    = FRAME_WORDS / 2;
   localparam int IW    = $clog2(FRAME_WORDS);
   localparam int DEPTH = 1 << AW;

   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_TAIL = 2'd2
   } state_t;

   // data FIFO
   logic [63:0]   r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          w_data_full;
   logic          w_data_empty;
   logic [63:0]   w_rd_word;

   // sync collection and sync FIFO (two frames of sync words)
   logic [IW-1:0] r_word_idx;
   logic [SW-1:0] r_sync_acc;
   logic [SW-1:0] w_sync_next;
   logic [SW-1:0] r_sync_mem [2];
   logic [1:0]    r_sync_wr;
   logic [1:0]    r_sync_rd;
   logic          w_sync_full;
   logic          w_sync_empty;
   logic          w_sync_pending;
   logic [SW-1:0] w_sync_head;
   logic [63:0]   w_tail_word;

   // output side
   state_t        r_state;
   logic [IW-1:0] r_out_idx;
   logic          r_out_vld;
   logic [63:0]   r_out_data;
   logic          r_out_last;
   logic [15:0]   r_frame_cnt;

   logic          w_push;
   logic          w_last_word;
   logic          w_load;
   logic [1:0]    w_sync_cnt;

   assign w_data_full  = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
   assign w_data_empty = (r_wr_ptr == r_rd_ptr);
   assign w_rd_word    = r_mem[r_rd_ptr[AW-1:0]];

   assign w_sync_full    = (r_sync_wr == {~r_sync_rd[1], r_sync_rd[0]});
   assign w_sync_empty   = (r_sync_wr == r_sync_rd);
   assign w_sync_cnt     = r_sync_wr - r_sync_rd;
   // a second complete frame already waits behind the one being finished
   assign w_sync_pending = (w_sync_cnt == 2'd2);
   assign w_sync_head    = r_sync_mem[r_sync_rd[0]];
   assign w_tail_word    = 64'(w_sync_head) << 48;

   // the final word of a frame also needs a free sync FIFO slot
   assign w_last_word = (r_word_idx == LAST_IDX);
   assign push_rdy    = ~w_data_full & ~(w_last_word & w_sync_full);
   assign w_push      = push_vld & push_rdy;

   // output register may take a new word when empty or being drained
   assign w_load = ~r_out_vld | out_rdy;

   assign out_vld   = r_out_vld;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign frame_cnt = r_frame_cnt;
   assign dbg_state = r_state;

   // sync accumulator with this cycle's bit merged in; even words only, MSB first
   always_comb begin
      w_sync_next = r_sync_acc;
      for (int k = 0; k < SW; k++) begin
         if (!r_word_idx[0] && (r_word_idx[IW-1:1] == (IW-1)'(SW - 1 - k))) begin
            w_sync_next[k] = push_isos;
         end
      end
   end

   // payload storage; contents need no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // write side: pointer, word index, sync accumulation and sync FIFO push
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr      <= '0;
         r_word_idx    <= '0;
         r_sync_acc    <= '0;
         r_sync_wr     <= '0;
         r_sync_mem[0] <= '0;
         r_sync_mem[1] <= '0;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_last_word) begin
            r_word_idx               <= '0;
            r_sync_acc               <= '0;
            r_sync_mem[r_sync_wr[0]] <= w_sync_next;
            r_sync_wr                <= r_sync_wr + 2'd1;
         end else begin
            r_word_idx <= r_word_idx + IDX_ONE;
            r_sync_acc <= w_sync_next;
         end
      end
   end

   // output FSM: waits for a complete frame, streams its data words, then the tail
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_rd_ptr    <= '0;
         r_out_idx   <= '0;
         r_sync_rd   <= '0;
         r_out_vld   <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (out_rdy) begin
                  r_out_vld <= 1'b0;
               end
               // a sync entry exists only once all its data words are stored
               if (!w_sync_empty) begin
                  r_state <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (w_load) begin
                  if (!w_data_empty) begin
                     r_out_vld  <= 1'b1;
                     r_out_data <= w_rd_word;
                     r_out_last <= 1'b0;
                     r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                     if (r_out_idx == LAST_IDX) begin
                        r_out_idx <= '0;
                        r_state   <= ST_TAIL;
                     end else begin
                        r_out_idx <= r_out_idx + IDX_ONE;
                     end
                  end else begin
                     r_out_vld <= 1'b0;
                  end
               end
            end

            ST_TAIL: begin
               if (r_out_vld && r_out_last && out_rdy) begin
                  // tail leaves: frame done, chain straight into the next frame if ready
                  r_sync_rd   <= r_sync_rd + 2'd1;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  if (w_sync_pending && !w_data_empty) begin
                     r_out_vld  <= 1'b1;
                     r_out_data <= w_rd_word;
                     r_out_last <= 1'b0;
                     r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                     r_out_idx  <= IDX_ONE;
                     r_state    <= ST_DATA;
                  end else begin
                     r_out_vld  <= 1'b0;
                     r_out_last <= 1'b0;
                     r_state    <= ST_IDLE;
                  end
               end else if (w_load && !r_out_last) begin
                  // last data word has left (or is leaving): present the tail
                  r_out_vld  <= 1'b1;
                  r_out_data <= w_tail_word;
                  r_out_last <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
